control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  6  instruction[31:26] of the fetched word.
REQ-006 RegDst  output  1  write-register select: 1 = rd, 0 = rt.
REQ-007 Branch  output  1  conditional branch (beq).
REQ-008 MemRead  output  1  data-memory read enable.
REQ-009 MemtoReg  output  1  writeback source: 1 = memory, 0 = ALU.
REQ-010 ALUOp  output  2  ALU class: 00 = add, 01 = subtract/compare, 10 = R-type (use funct).
REQ-011 MemWrite  output  1  data-memory write enable.
REQ-012 ALUSrc  output  1  ALU operand B: 1 = sign-extended immediate, 0 = register.
REQ-013 RegWrite  output  1  register-file write enable.
REQ-014 Jump  output  1  unconditional jump.
REQ-015 Illegal  output  1  opcode is not one of the decoded opcodes below.

Function
REQ-016 All outputs SHALL be registered: opcode is sampled on each rising clk edge while rst_n=1, and outputs reflect it one cycle later (latency 1, no combinational path from opcode to outputs).
REQ-017 opcode 000000 (R-type) SHALL decode as follows.
- RegDst=1, RegWrite=1, ALUOp=10.
- All other controls 0.
REQ-018 opcode 100011 (lw) SHALL decode as follows.
- ALUSrc=1, MemtoReg=1, RegWrite=1, MemRead=1, ALUOp=00.
- All other controls 0.
REQ-019 opcode 101011 (sw) SHALL decode as follows.
- ALUSrc=1, MemWrite=1, ALUOp=00.
- All other controls 0; RegDst and MemtoReg are driven 0, not don't-care.
REQ-020 opcode 000100 (beq) SHALL decode as follows.
- Branch=1, ALUOp=01.
- All other controls 0.
REQ-021 opcode 001000 (addi) SHALL decode as follows.
- ALUSrc=1, RegWrite=1, ALUOp=00.
- All other controls 0.
REQ-022 opcode 000010 (j) SHALL decode as follows.
- Jump=1.
- All other controls 0, ALUOp=00.
REQ-023 Any other opcode SHALL drive every control output to 0 and ALUOp=00, with Illegal=1.
- Side-effecting controls (RegWrite, MemWrite, MemRead, Branch, Jump) therefore stay inactive.
REQ-024 Illegal SHALL be 0 for every decoded opcode.
REQ-025 At most one of Branch, Jump, MemRead, MemWrite SHALL be 1 in any cycle.
REQ-026 X or Z bits on opcode SHALL be treated as an undecoded opcode (REQ-023).
REQ-027 Back-to-back opcode changes on consecutive edges SHALL each produce their own decode in successive cycles, with no hold or bubble.

Reset
REQ-028 When rst_n=0, all outputs SHALL clear asynchronously, regardless of clk.
- Cleared outputs: RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, Jump, Illegal.
- All clear to 0.
REQ-029 Outputs SHALL stay 0 while rst_n=0.
REQ-030 The first decode after reset SHALL appear one cycle after the first rising clk edge with rst_n=1.
REQ-031 If rst_n is asserted mid-operation, outputs SHALL drop to 0 immediately; the in-flight opcode is discarded.

Verification
REQ-032 Reset: rst_n=0 with opcode=000000 -> all outputs 0, Illegal=0; release rst_n, one edge -> RegDst=1, RegWrite=1, ALUOp=10.
REQ-033 Sweep: apply 100011, 101011, 000100, 001000, 000010 on consecutive edges -> each decode matches REQ-018..REQ-022 exactly one cycle after its edge.
REQ-034 Illegal: opcode=111111 -> one cycle later all controls 0, ALUOp=00, Illegal=1; then opcode=000000 -> Illegal=0 the next cycle.
REQ-035 Async reset: assert rst_n between edges while outputs show lw -> MemRead, MemtoReg, RegWrite, ALUSrc drop to 0 before the next clk edge.
REQ-036 Exclusivity: exhaustive loop over all 64 opcodes -> at most one of Branch/Jump/MemRead/MemWrite set, and Illegal=1 for exactly 58 opcodes.

Source files
------------

// File: rtl/control_unit.sv
// control_unit -- registered main decoder for a single-cycle MIPS-style core.
//
// Decodes instruction[31:26] into datapath control strobes. Every output is
// a flop, so the decode of the opcode sampled on a rising edge appears one
// cycle later; there is no combinational path from opcode to any output.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, clears every output
//   opcode    in   [5:0] instruction[31:26]
//   RegDst    out  write-register select (1 = rd, 0 = rt)
//   Branch    out  beq
//   MemRead   out  data-memory read enable
//   MemtoReg  out  writeback source (1 = memory, 0 = ALU)
//   ALUOp     out  [1:0] 00 add, 01 sub/compare, 10 R-type (funct)
//   MemWrite  out  data-memory write enable
//   ALUSrc    out  ALU operand B (1 = sign-extended immediate)
//   RegWrite  out  register-file write enable
//   Jump      out  unconditional jump
//   Illegal   out  opcode not recognised
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  output logic       RegDst,
  output logic       Branch,
  output logic       MemRead,
  output logic       MemtoReg,
  output logic [1:0] ALUOp,
  output logic       MemWrite,
  output logic       ALUSrc,
  output logic       RegWrite,
  output logic       Jump,
  output logic       Illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  ctrl_t ctrl_d, ctrl_q;

  // Everything defaults to 0 so each arm only lists its active strobes.
  // A 4-state X/Z opcode matches no arm and lands in default (illegal),
  // which also keeps every side-effecting strobe low.
  always_comb begin
    ctrl_d = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_d.reg_dst   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_RTYPE;
      end
      OP_LW: begin
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
      end
      OP_ADDI: begin
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = ALU_ADD;
      end
      OP_J: begin
        ctrl_d.jump = 1'b1;
      end
      default: begin
        ctrl_d.illegal = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign RegDst   = ctrl_q.reg_dst;
  assign Branch   = ctrl_q.branch;
  assign MemRead  = ctrl_q.mem_read;
  assign MemtoReg = ctrl_q.mem_to_reg;
  assign ALUOp    = ctrl_q.alu_op;
  assign MemWrite = ctrl_q.mem_write;
  assign ALUSrc   = ctrl_q.alu_src;
  assign RegWrite = ctrl_q.reg_write;
  assign Jump     = ctrl_q.jump;
  assign Illegal  = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       RegDst, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, Jump, Illegal;
  logic [1:0] ALUOp;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .RegDst(RegDst), .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg),
    .ALUOp(ALUOp), .MemWrite(MemWrite), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
    .Jump(Jump), .Illegal(Illegal)
  );

  // {RegDst,Branch,MemRead,MemtoReg,ALUOp[1:0],MemWrite,ALUSrc,RegWrite,Jump,Illegal}
  logic [10:0] obs;
  assign obs = {RegDst, Branch, MemRead, MemtoReg, ALUOp, MemWrite, ALUSrc, RegWrite, Jump, Illegal};

  // Reference: each output written as the set of instructions that need it.
  function automatic logic [10:0] model(input logic [5:0] op);
    bit is_r, is_lw, is_sw, is_beq, is_addi, is_j, legal;
    logic [1:0] aluop;
    is_r    = (op === 6'd0);
    is_lw   = (op === 6'd35);
    is_sw   = (op === 6'd43);
    is_beq  = (op === 6'd4);
    is_addi = (op === 6'd8);
    is_j    = (op === 6'd2);
    legal   = is_r || is_lw || is_sw || is_beq || is_addi || is_j;
    aluop   = is_r ? 2'd2 : (is_beq ? 2'd1 : 2'd0);
    return {is_r, is_beq, is_lw, is_lw, aluop, is_sw,
            (is_lw || is_sw || is_addi), (is_r || is_lw || is_addi), is_j, !legal};
  endfunction

  function automatic logic [5:0] pick_op();
    logic [5:0] legal_ops [6] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd8, 6'd2};
    if ($urandom_range(1, 0) == 1) return legal_ops[$urandom_range(5, 0)];
    return 6'($urandom);
  endfunction

  task automatic test_reset();
    rst_n  = 1'b0;
    opcode = 6'd0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (obs !== 11'd0) begin
      n_err++;
      $display("FAIL reset_held: got %b expected %b", obs, 11'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== 11'b1_0_0_0_10_0_0_1_0_0) begin
      n_err++;
      $display("FAIL reset_first_decode: got %b expected %b", obs, 11'b10001000100);
    end
  endtask

  task automatic test_sweep();
    logic [5:0] ops [5] = '{6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    foreach (ops[i]) begin
      opcode = ops[i];
      @(negedge clk);
      n_cmp++;
      if (obs !== model(ops[i])) begin
        n_err++;
        $display("FAIL sweep op=%b: got %b expected %b", ops[i], obs, model(ops[i]));
      end
    end
  endtask

  task automatic test_illegal();
    opcode = 6'b111111;
    @(negedge clk);
    n_cmp++;
    if (obs !== 11'b0_0_0_0_00_0_0_0_0_1) begin
      n_err++;
      $display("FAIL illegal_111111: got %b expected %b", obs, 11'b1);
    end
    opcode = 6'b000000;
    @(negedge clk);
    n_cmp++;
    if (Illegal !== 1'b0 || obs !== model(6'd0)) begin
      n_err++;
      $display("FAIL illegal_clear: got %b expected %b", obs, model(6'd0));
    end
  endtask

  task automatic test_async_reset();
    opcode = 6'b100011;
    @(negedge clk);
    n_cmp++;
    if (obs !== model(6'b100011)) begin
      n_err++;
      $display("FAIL async_pre_lw: got %b expected %b", obs, model(6'b100011));
    end
    // Mid low phase, well before the next rising edge.
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 11'd0) begin
      n_err++;
      $display("FAIL async_drop: got %b expected %b", obs, 11'd0);
    end
    opcode = 6'b000100;
    @(negedge clk);
    n_cmp++;
    if (obs !== 11'd0) begin
      n_err++;
      $display("FAIL async_stay_low: got %b expected %b", obs, 11'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== model(6'b000100)) begin
      n_err++;
      $display("FAIL async_first_after: got %b expected %b", obs, model(6'b000100));
    end
  endtask

  task automatic test_exhaustive();
    int n_illegal = 0;
    for (int op = 0; op < 64; op++) begin
      opcode = 6'(op);
      @(negedge clk);
      n_cmp++;
      if (obs !== model(6'(op))) begin
        n_err++;
        $display("FAIL exhaustive op=%0d: got %b expected %b", op, obs, model(6'(op)));
      end
      n_cmp++;
      if ((int'(Branch) + int'(Jump) + int'(MemRead) + int'(MemWrite)) > 1) begin
        n_err++;
        $display("FAIL exclusive op=%0d: got B%b J%b R%b W%b expected at most one set",
                 op, Branch, Jump, MemRead, MemWrite);
      end
      if (Illegal === 1'b1) n_illegal++;
    end
    n_cmp++;
    if (n_illegal != 58) begin
      n_err++;
      $display("FAIL illegal_count: got %0d expected 58", n_illegal);
    end
  endtask

  // Random opcodes on every edge: each decode must follow its own opcode
  // one cycle later with no holds or bubbles.
  task automatic test_back_to_back();
    logic [5:0] op;
    for (int i = 0; i < 300; i++) begin
      op = pick_op();
      opcode = op;
      @(negedge clk);
      n_cmp++;
      if (obs !== model(op)) begin
        n_err++;
        $display("FAIL back_to_back i=%0d op=%b: got %b expected %b", i, op, obs, model(op));
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_illegal();
    test_async_reset();
    test_exhaustive();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
